// File: rtl/spi_master_arb.sv
// spi_master_arb: shares one SPI link to an 8-bit slave among NUM_REQ requesters.
// Latency: grant to done is CS_SETUP + 8*(SCK_LOW+1) + CS_HOLD + 1 clks, counting both ends.
// Backpressure: req is a level held until done; later requesters wait for the link to free up.
//
// Ports: clk/rst (async active-high); req/tx_data per requester; grant/done per requester;
//        rx_data received byte; busy; cs/sck/mosi/miso slave pins.
// Optional macro SPI_ARB_FIXED_PRIO_EN: lowest active index always wins, and there is no rr pointer.
// By default (macro undefined) the link is granted round-robin.
module spi_master_arb #(
    parameter int NUM_REQ  = 2,
    parameter int SCK_LOW  = 3,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] tx_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rx_data,
    output logic                 busy,
    output logic                 cs,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso
);
    localparam int MAX_AB = (SCK_LOW > CS_SETUP) ? SCK_LOW : CS_SETUP;
    localparam int MAXC   = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               win_vld;
    logic [PW-1:0]      win_idx;
    logic               take;

    // DONE also arbitrates, so a waiting requester gets the link right after
    // the one-clk cs-high gap instead of passing through IDLE first.
    assign take = ((state_q == S_IDLE) || (state_q == S_DONE)) && win_vld;

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        // Descending scan: the lowest active index is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_vld = 1'b1;
                win_idx = PW'(k);
            end
        end
    end
`else
    logic [PW-1:0] rr_q, rr_d;

    always_comb begin : rr_arb
        int j;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        // Descending scan by offset from the pointer: the nearest active requester
        // at or after rr_q is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_q) + k) % NUM_REQ;
            if (req[j]) begin
                win_vld = 1'b1;
                win_idx = PW'(j);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (take) begin
            rr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        grant_d   = grant_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                if (take) begin
                    state_d = S_SETUP;
                    grant_d = NUM_REQ'(1) << win_idx;
                    tx_d    = tx_data[int'(win_idx)*8 +: 8];
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // Counts 0..SCK_LOW-1 are the low phase, and SCK_LOW is the single high clk.
                if (cnt_q == CW'(SCK_LOW - 1)) begin
                    rx_d = {rx_q[6:0], miso};
                end
                if (cnt_q == CW'(SCK_LOW)) begin
                    cnt_d = '0;
                    tx_d  = {tx_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    rx_data_d = rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            grant_q   <= grant_d;
        end
    end

    // Pin outputs are decoded from state, so an asynchronous reset forces cs high
    // and sck low immediately, without waiting for a clock edge.
    assign cs      = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
    assign sck     = (state_q == S_SHIFT) && (cnt_q == CW'(SCK_LOW));
    assign mosi    = ((state_q == S_SETUP) || (state_q == S_SHIFT)) ? tx_q[7] : 1'b0;
    assign busy    = (state_q != S_IDLE);
    assign grant   = grant_q;
    assign done    = (state_q == S_DONE) ? grant_q : '0;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_arb.sv
module tb_spi_master_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter DUT (d_*) and a fast-timing DUT (f_*), each with its own slave model.
    logic [1:0]  d_req = '0, f_req = '0;
    logic [15:0] d_tx = '0, f_tx = '0;
    logic [1:0]  d_grant, d_done, f_grant, f_done;
    logic [7:0]  d_rx, f_rx;
    logic        d_busy, d_cs, d_sck, d_mosi, d_miso;
    logic        f_busy, f_cs, f_sck, f_mosi, f_miso;
    logic [7:0]  d_stx = 8'h00, f_stx = 8'h00, d_ssh, f_ssh;

    spi_master_arb u_dut (
        .clk(clk), .rst(rst), .req(d_req), .tx_data(d_tx), .grant(d_grant), .done(d_done),
        .rx_data(d_rx), .busy(d_busy), .cs(d_cs), .sck(d_sck), .mosi(d_mosi), .miso(d_miso)
    );

    spi_master_arb #(.NUM_REQ(2), .SCK_LOW(1), .CS_SETUP(1), .CS_HOLD(1)) u_fast (
        .clk(clk), .rst(rst), .req(f_req), .tx_data(f_tx), .grant(f_grant), .done(f_done),
        .rx_data(f_rx), .busy(f_busy), .cs(f_cs), .sck(f_sck), .mosi(f_mosi), .miso(f_miso)
    );

    // Slave: reloads its byte while cs is high and shifts on each clk that sck is high.
    always @(posedge clk) begin
        if (d_cs) d_ssh <= d_stx;
        else if (d_sck) d_ssh <= {d_ssh[6:0], d_mosi};
        if (f_cs) f_ssh <= f_stx;
        else if (f_sck) f_ssh <= {f_ssh[6:0], f_mosi};
    end
    assign d_miso = d_ssh[7];
    assign f_miso = f_ssh[7];

    logic       sel = 1'b0;
    logic [1:0] o_grant, o_done;
    logic [7:0] o_rx, o_ssh;
    logic       o_busy, o_cs, o_sck, o_mosi;
    assign o_grant = sel ? f_grant : d_grant;
    assign o_done  = sel ? f_done  : d_done;
    assign o_rx    = sel ? f_rx    : d_rx;
    assign o_ssh   = sel ? f_ssh   : d_ssh;
    assign o_busy  = sel ? f_busy  : d_busy;
    assign o_cs    = sel ? f_cs    : d_cs;
    assign o_sck   = sel ? f_sck   : d_sck;
    assign o_mosi  = sel ? f_mosi  : d_mosi;

    typedef struct {
        int         owner;
        logic [7:0] rx;
        logic [7:0] sl;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;

    task automatic wait_grant(output bit tmo);
        tmo = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_grant != 2'b00) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    // Called on the negedge where grant is first visible (lat=1). Runs until done is seen.
    task automatic collect(input int limit, input int slow, output int lat, output logic [7:0] mb,
                           output int highs, output int badlow, output int sckcs,
                           output logic [1:0] dn, output bit tmo);
        int lowrun;
        lat = 1; mb = '0; highs = 0; badlow = 0; sckcs = 0; dn = '0; tmo = 1'b1; lowrun = 0;
        for (int c = 0; c < limit; c++) begin
            if (o_sck && o_cs) sckcs++;
            if (o_sck) begin
                mb = {mb[6:0], o_mosi};
                if (highs > 0 && lowrun != slow) badlow++;
                highs++;
                lowrun = 0;
            end else begin
                lowrun++;
            end
            if (o_done != 2'b00) begin
                dn  = o_done;
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; d_req = '0; f_req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (o_grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", o_grant); else passes++;
        checks++; if (o_done !== 2'b00) $display("FAIL reset_done: got %b want 00", o_done); else passes++;
        checks++; if (o_rx !== 8'h00) $display("FAIL reset_rx: got %h want 00", o_rx); else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else passes++;
        checks++; if (o_cs !== 1'b1) $display("FAIL reset_cs: got %b want 1", o_cs); else passes++;
        checks++; if (o_sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", o_sck); else passes++;
        checks++; if (o_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", o_mosi); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat, highs, badlow, sckcs; logic [7:0] mb; logic [1:0] dn; bit tmo; exp_t e;
        sel = 1'b0; d_stx = 8'h3C; d_tx = 16'h00A5;
        exp_q.push_back('{owner: 0, rx: 8'h3C, sl: 8'hA5});
        d_req = 2'b01;
        @(negedge clk);
        checks++; if (o_grant !== 2'b01) $display("FAIL single_grant: got %b want 01", o_grant); else passes++;
        collect(60, 3, lat, mb, highs, badlow, sckcs, dn, tmo);
        d_req = 2'b00;
        e = exp_q.pop_front();
        checks++; if (tmo) $display("FAIL single_timeout: got no done want done"); else passes++;
        checks++; if (lat != 37) $display("FAIL single_latency: got %0d want 37", lat); else passes++;
        checks++; if (mb !== 8'hA5) $display("FAIL single_mosi: got %h want a5", mb); else passes++;
        checks++; if (dn !== 2'(1 << e.owner)) $display("FAIL single_done: got %b want %b", dn, 2'(1 << e.owner)); else passes++;
        checks++; if (o_rx !== e.rx) $display("FAIL single_rx: got %h want %h", o_rx, e.rx); else passes++;
        checks++; if (o_ssh !== e.sl) $display("FAIL single_slave: got %h want %h", o_ssh, e.sl); else passes++;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0 || o_grant !== 2'b00 || o_cs !== 1'b1)
            $display("FAIL single_idle: got busy=%b grant=%b cs=%b want 0 00 1", o_busy, o_grant, o_cs); else passes++;
    endtask

    task automatic test_sck_shape();
        int lat, highs, badlow, sckcs; logic [7:0] mb; logic [1:0] dn; bit tmo; exp_t e;
        sel = 1'b0; d_stx = 8'hE1; d_tx = 16'h0069;
        exp_q.push_back('{owner: 0, rx: 8'hE1, sl: 8'h69});
        d_req = 2'b01;
        wait_grant(tmo);
        checks++; if (tmo) $display("FAIL shape_grant: got none want grant"); else passes++;
        collect(60, 3, lat, mb, highs, badlow, sckcs, dn, tmo);
        d_req = 2'b00;
        e = exp_q.pop_front();
        checks++; if (highs != 8) $display("FAIL shape_highs: got %0d want 8", highs); else passes++;
        checks++; if (badlow != 0) $display("FAIL shape_phase: got %0d bad phases want 0", badlow); else passes++;
        checks++; if (sckcs != 0) $display("FAIL shape_sck_cs: got %0d want 0", sckcs); else passes++;
        checks++; if (o_rx !== e.rx) $display("FAIL shape_rx: got %h want %h", o_rx, e.rx); else passes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (o_sck !== 1'b0) $display("FAIL shape_idle_sck: got %b want 0", o_sck); else passes++;
        end
    endtask

    task automatic test_contention();
        int lat, highs, badlow, sckcs; logic [7:0] mb; logic [1:0] dn; bit tmo; exp_t e;
        int own;
        do_reset();
        sel = 1'b0; d_stx = 8'h5A; d_tx = 16'h2211;
        for (int i = 0; i < 4; i++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            own = 0;
`else
            own = i % 2;
`endif
            exp_q.push_back('{owner: own, rx: 8'h5A, sl: (own == 1) ? 8'h22 : 8'h11});
        end
        d_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                wait_grant(tmo);
                checks++; if (tmo) $display("FAIL cont_grant: got none want grant"); else passes++;
            end else begin
                @(negedge clk);
                checks++; if (o_cs !== 1'b0) $display("FAIL cont_gap: xfer %0d got cs=%b want 0", i, o_cs); else passes++;
            end
            checks++; if (o_grant !== 2'(1 << exp_q[0].owner))
                $display("FAIL cont_order: xfer %0d got %b want %b", i, o_grant, 2'(1 << exp_q[0].owner)); else passes++;
            collect(60, 3, lat, mb, highs, badlow, sckcs, dn, tmo);
            if (i == 3) d_req = 2'b00;
            e = exp_q.pop_front();
            checks++; if (dn !== 2'(1 << e.owner)) $display("FAIL cont_done: got %b want %b", dn, 2'(1 << e.owner)); else passes++;
            checks++; if (o_ssh !== e.sl) $display("FAIL cont_slave: got %h want %h", o_ssh, e.sl); else passes++;
            checks++; if (o_cs !== 1'b1) $display("FAIL cont_done_cs: got %b want 1", o_cs); else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_midreset();
        int lat, highs, badlow, sckcs; logic [7:0] mb; logic [1:0] dn; bit tmo; exp_t e;
        sel = 1'b0; d_stx = 8'h81; d_tx = 16'h0033; d_req = 2'b01;
        wait_grant(tmo);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (o_cs !== 1'b1 || o_sck !== 1'b0 || o_grant !== 2'b00 || o_busy !== 1'b0)
            $display("FAIL midrst_outputs: got cs=%b sck=%b grant=%b busy=%b want 1 0 00 0", o_cs, o_sck, o_grant, o_busy); else passes++;
        @(negedge clk);
        rst = 1'b0; d_stx = 8'h96; d_tx = 16'h00C3;
        exp_q.push_back('{owner: 0, rx: 8'h96, sl: 8'hC3});
        wait_grant(tmo);
        checks++; if (tmo) $display("FAIL midrst_grant: got none want grant"); else passes++;
        collect(60, 3, lat, mb, highs, badlow, sckcs, dn, tmo);
        d_req = 2'b00;
        e = exp_q.pop_front();
        checks++; if (lat != 37) $display("FAIL midrst_latency: got %0d want 37", lat); else passes++;
        checks++; if (o_rx !== e.rx) $display("FAIL midrst_rx: got %h want %h", o_rx, e.rx); else passes++;
        checks++; if (o_ssh !== e.sl) $display("FAIL midrst_slave: got %h want %h", o_ssh, e.sl); else passes++;
        @(negedge clk);
    endtask

    task automatic test_owner_drop();
        int lat, highs, badlow, sckcs; logic [7:0] mb; logic [1:0] dn; bit tmo; exp_t e;
        sel = 1'b0; d_stx = 8'hA7; d_tx = 16'h005C;
        exp_q.push_back('{owner: 0, rx: 8'hA7, sl: 8'h5C});
        d_req = 2'b01;
        wait_grant(tmo);
        repeat (10) @(negedge clk);
        d_req = 2'b00; d_tx = 16'h00FF;
        collect(60, 3, lat, mb, highs, badlow, sckcs, dn, tmo);
        e = exp_q.pop_front();
        checks++; if (dn !== 2'(1 << e.owner)) $display("FAIL drop_done: got %b want %b", dn, 2'(1 << e.owner)); else passes++;
        checks++; if (o_ssh !== e.sl) $display("FAIL drop_slave: got %h want %h", o_ssh, e.sl); else passes++;
        checks++; if (o_rx !== e.rx) $display("FAIL drop_rx: got %h want %h", o_rx, e.rx); else passes++;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0) $display("FAIL drop_idle: got busy=%b want 0", o_busy); else passes++;
    endtask

    task automatic test_sweep();
        int lat, highs, badlow, sckcs; logic [7:0] mb; logic [1:0] dn; bit tmo; exp_t e;
        logic [7:0] pat;
        sel = 1'b1;
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? 8'hFF : 8'h00;
            f_tx = {8'h00, pat}; f_stx = ~pat;
            exp_q.push_back('{owner: 0, rx: ~pat, sl: pat});
            f_req = 2'b01;
            wait_grant(tmo);
            collect(40, 1, lat, mb, highs, badlow, sckcs, dn, tmo);
            f_req = 2'b00;
            e = exp_q.pop_front();
            checks++; if (lat != 19) $display("FAIL sweep_latency: got %0d want 19", lat); else passes++;
            checks++; if (mb !== e.sl) $display("FAIL sweep_mosi: got %h want %h", mb, e.sl); else passes++;
            checks++; if (o_rx !== e.rx) $display("FAIL sweep_rx: got %h want %h", o_rx, e.rx); else passes++;
            checks++; if (o_ssh !== e.sl) $display("FAIL sweep_slave: got %h want %h", o_ssh, e.sl); else passes++;
            checks++; if (highs != 8 || badlow != 0) $display("FAIL sweep_shape: got highs=%0d bad=%0d want 8 0", highs, badlow); else passes++;
            @(negedge clk);
        end
        sel = 1'b0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_sck_shape();
        test_contention();
        test_midreset();
        test_owner_drop();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- Arbitrated SPI master that shares one serial link to the 8-bit SPI slave among NUM_REQ on-chip requesters.
- Each requester posts an 8-bit transfer. The block grants the link round-robin, drives cs/sck/mosi, captures miso, and returns the received byte with a done pulse to the granted requester.
- Sits between internal agents and the slave's cs/sck/mosi/miso pins. All logic is on the same clk as the slave.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- SCK_LOW, 3, clk cycles sck is held low per bit (>=1). The sck high phase is fixed at exactly 1 clk, because the slave shifts on every clk while sck is high.
- CS_SETUP, 2, clk cycles from cs falling to the first sck high (>=1).
- CS_HOLD, 2, clk cycles from the last sck high to cs rising (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req  in  NUM_REQ  per-requester transfer request, level; held until that requester's done
- tx_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]; sampled at grant
- grant  out  NUM_REQ  one-hot owner of the current transfer; all zero when idle
- done  out  NUM_REQ  1-clk pulse to the owner when its transfer completes
- rx_data  out  8  byte captured from miso, MSB first; valid from done onward
- busy  out  1  high from grant to done inclusive
- cs  out  1  chip select, active low
- sck  out  1  serial clock, idle low
- mosi  out  1  serial data out, MSB first
- miso  in  1  serial data in

Behaviour:
- Reset values: grant=0, done=0, rx_data=8'h00, busy=0, cs=1, sck=0, mosi=0, rr pointer=0, FSM in IDLE.
- IDLE:
  - If any req is high, choose the first requester at or after the rr pointer (wrapping modulo NUM_REQ).
  - On the next edge: set grant one-hot, latch its tx_data into the shift register, set busy=1, go to SETUP.
  - In the same edge, the rr pointer moves to winner+1 (wrapping to 0 after NUM_REQ-1).
- SETUP:
  - cs=0; mosi=shift[7].
  - Count CS_SETUP cycles, then go to SHIFT.
- SHIFT: 8 bits, each SCK_LOW+1 clks.
  - Low phase: sck=0, mosi=current bit.
  - Final low cycle: sample miso into rx shift.
  - High phase: sck=1 for exactly 1 clk; mosi stable.
  - After the high cycle, the tx shift advances (next bit on mosi).
  - Bit counter runs 0..7; after bit 7's high cycle, go to HOLD.
- HOLD:
  - cs=0, sck=0.
  - Count CS_HOLD cycles, then go to DONE.
- DONE (1 clk):
  - cs=1; rx_data<=captured byte; done[owner]=1.
  - grant cleared; busy=0; return to IDLE.
- Timing:
  - A new grant can occur at the earliest on the clk after DONE, so cs is high for at least 1 clk between transfers.
  - Total transfer latency, grant to done: CS_SETUP + 8*(SCK_LOW+1) + CS_HOLD + 1 clks (defaults: 37).
- req handling:
  - req changes during a transfer do not affect it.
  - If the owner deasserts req mid-transfer, the transfer still completes and done still pulses.
  - tx_data changes after grant are ignored.
- Simultaneous requests: resolved by rr order only. No requester waits more than NUM_REQ-1 transfers.
- Reset mid-transfer: immediate return to reset values (cs=1 asynchronously, sck=0); the partial byte is discarded.
- Counters: sized for max(SCK_LOW, CS_SETUP, CS_HOLD). Bit counter is 3 bits and exits on value 7; no wrap is used.

Optional Feature:
- SPI_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority; the lowest index among active req wins; rr pointer removed.
  - Undefined (default): round-robin as above.

Test Plan:
- Single transfer: req=2'b01, tx_data[7:0]=8'hA5, miso driven 8'h3C MSB first.
  - grant=01 the next clk.
  - mosi bit sequence 1,0,1,0,0,1,0,1 across the 8 sck highs.
  - done[0] pulses 37 clks after grant; rx_data=8'h3C.
  - Attached slave's data_out=8'hA5.
- Contention: req=2'b11 from reset, tx bytes 8'h11/8'h22.
  - Order is 0 then 1; cs high exactly 1 clk between them.
  - With req held at 2'b11, the next order is 0, 1, 0, 1.
  - Under SPI_ARB_FIXED_PRIO_EN, requester 0 is granted every time.
- sck shape: every sck high is 1 clk; every low phase is SCK_LOW=3 clks; exactly 8 highs per cs-low window; sck=0 whenever cs=1.
- Mid-transfer reset: assert rst during bit 4 → cs=1, sck=0, grant=0, busy=0 the same cycle. After release with req=01, the new transfer completes normally.
- Owner drops req during bit 2 and changes tx_data → the byte sent is still the originally latched value; done pulses.
- Parameter sweep SCK_LOW=1, CS_SETUP=1, CS_HOLD=1 → latency 19 clks; the 8'hFF/8'h00 patterns loop back correctly.
